// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and types for the seven-segment scan driver.
//   SEG_0..SEG_F : active-low CA..CG patterns (bit6 = CA ... bit0 = CG)
//   SEG_OFF      : all cathodes off, including DP
//   seg7_phase_t : slot phase (BLANK dead time, SHOW digit lit)
//   msd_index()  : index of the highest non-zero nibble (0 when value is 0)
package seg7_pkg;

  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b1100000;
  localparam logic [6:0] SEG_C = 7'b0110001;
  localparam logic [6:0] SEG_D = 7'b1000010;
  localparam logic [6:0] SEG_E = 7'b0110000;
  localparam logic [6:0] SEG_F = 7'b0111000;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } seg7_phase_t;

  function automatic logic [2:0] msd_index(input logic [31:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (v[4*i +: 4] != 4'h0) r = 3'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_hex_enc.sv
// seg7_hex_enc: combinational hex nibble to seven-segment pattern lookup.
//   i_nibble  in  4 : hex digit
//   o_pattern out 7 : active-low CA..CG (bit6 = CA)
module seg7_hex_enc
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_pattern
);

  always_comb begin
    o_pattern = SEG_8;
    case (i_nibble)
      4'h0: o_pattern = SEG_0;
      4'h1: o_pattern = SEG_1;
      4'h2: o_pattern = SEG_2;
      4'h3: o_pattern = SEG_3;
      4'h4: o_pattern = SEG_4;
      4'h5: o_pattern = SEG_5;
      4'h6: o_pattern = SEG_6;
      4'h7: o_pattern = SEG_7;
      4'h8: o_pattern = SEG_8;
      4'h9: o_pattern = SEG_9;
      4'hA: o_pattern = SEG_A;
      4'hB: o_pattern = SEG_B;
      4'hC: o_pattern = SEG_C;
      4'hD: o_pattern = SEG_D;
      4'hE: o_pattern = SEG_E;
      4'hF: o_pattern = SEG_F;
      default: o_pattern = SEG_8;
    endcase
  end

endmodule

// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed driver for an eight-digit common-anode
// seven-segment display. Inputs are snapshotted once per frame; each digit
// slot begins with DEAD blanked cycles to suppress ghosting.
//
// Optional build macro: SEG7_LZ_BLANK_EN enables leading-zero suppression.
//
// Ports:
//   clk         in  1  : system clock
//   rst         in  1  : synchronous active-high reset
//   value       in  32 : digit i shows value[4i+3:4i]
//   dp_mask     in  8  : bit i lights DP on digit i
//   digit_en    in  8  : bit i = 0 keeps digit i dark
//   seg         out 8  : active-low cathodes, bit7 = CA .. bit1 = CG, bit0 = DP
//   an          out 8  : active-low anodes, bit i = digit i
//   frame_start out 1  : one-cycle pulse per snapshot load
//
// Phase FSM:
//   state | meaning
//   BLANK | pcnt < DEAD, all anodes and cathodes off
//   SHOW  | pcnt >= DEAD, current digit driven if enabled
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int DIV_W = 11,
  parameter int DEAD  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value,
  input  logic [7:0]  dp_mask,
  input  logic [7:0]  digit_en,
  output logic [7:0]  seg,
  output logic [7:0]  an,
  output logic        frame_start
);

  localparam logic [DIV_W-1:0] DEAD_C = DEAD[DIV_W-1:0];

  logic [DIV_W-1:0] r_pcnt;
  logic [2:0]       r_idx;
  seg7_phase_t      r_state;
  logic [31:0]      r_val;
  logic [7:0]       r_dp;
  logic [7:0]       r_en;
  logic [7:0]       r_seg;
  logic [7:0]       r_an;
  logic             r_fs;

  seg7_phase_t      w_state_next;
  logic [DIV_W-1:0] w_pcnt_next;
  logic             w_snap;
  logic [31:0]      w_cur_val;
  logic [7:0]       w_cur_dp;
  logic [7:0]       w_cur_en;
  logic [3:0]       w_nib;
  logic [6:0]       w_pat;
  logic             w_lz_off;
  logic [7:0]       w_seg_next;
  logic [7:0]       w_an_next;

  assign w_pcnt_next = r_pcnt + 1'b1;
  assign w_snap      = (r_idx == 3'd0) && (r_pcnt == '0);

  // On the snapshot cycle the shadow registers still hold the previous
  // frame, so bypass to the incoming values; this only matters when DEAD=0.
  assign w_cur_val = w_snap ? value    : r_val;
  assign w_cur_dp  = w_snap ? dp_mask  : r_dp;
  assign w_cur_en  = w_snap ? digit_en : r_en;
  assign w_nib     = w_cur_val[4*r_idx +: 4];

`ifdef SEG7_LZ_BLANK_EN
  logic [2:0] r_msd;
  logic [2:0] w_cur_msd;

  assign w_cur_msd = w_snap ? msd_index(value) : r_msd;
  // Digit 0 always shows; a lit DP keeps a leading zero visible.
  assign w_lz_off  = (r_idx != 3'd0) && (r_idx > w_cur_msd) && !w_cur_dp[r_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_msd <= 3'd0;
    end else if (w_snap) begin
      r_msd <= msd_index(value);
    end
  end
`else
  assign w_lz_off = 1'b0;
`endif

  seg7_hex_enc u_hex_enc (
    .i_nibble  (w_nib),
    .o_pattern (w_pat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pcnt  <= '0;
      r_idx   <= 3'd0;
      r_state <= BLANK;
      r_val   <= 32'h0;
      r_dp    <= 8'h0;
      r_en    <= 8'h0;
      r_seg   <= SEG_OFF;
      r_an    <= 8'hFF;
      r_fs    <= 1'b0;
    end else begin
      r_pcnt  <= w_pcnt_next;
      r_state <= w_state_next;
      if (&r_pcnt) r_idx <= r_idx + 3'd1;
      if (w_snap) begin
        r_val <= value;
        r_dp  <= dp_mask;
        r_en  <= digit_en;
      end
      r_seg <= w_seg_next;
      r_an  <= w_an_next;
      r_fs  <= w_snap;
    end
  end

  // State tracks the phase of the pcnt value loaded alongside it.
  always_comb begin
    w_state_next = r_state;
    w_seg_next   = SEG_OFF;
    w_an_next    = 8'hFF;
    if (w_pcnt_next < DEAD_C) w_state_next = BLANK;
    else                      w_state_next = SHOW;
    if ((r_state == SHOW) && w_cur_en[r_idx] && !w_lz_off) begin
      w_an_next  = ~(8'b1 << r_idx);
      w_seg_next = {w_pat, ~w_cur_dp[r_idx]};
    end
  end

  assign seg         = r_seg;
  assign an          = r_an;
  assign frame_start = r_fs;

endmodule

// File: tb/tb_seg7_scan.sv
module tb_seg7_scan;

  logic        clk;
  logic        rst;
  logic [31:0] value;
  logic [7:0]  dp_mask;
  logic [7:0]  digit_en;
  logic [7:0]  seg;
  logic [7:0]  an;
  logic        frame_start;

  int errors = 0;
  int checks = 0;
  int k_cyc  = 0;

  typedef struct packed {
    logic [7:0] seg;
    logic [7:0] an;
    logic       fs;
  } exp_t;

  exp_t sb_q[$];

  seg7_scan #(.DIV_W(4), .DEAD(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .value       (value),
    .dp_mask     (dp_mask),
    .digit_en    (digit_en),
    .seg         (seg),
    .an          (an),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] exp_hex(input logic [3:0] n);
    case (n)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;
      4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;
      4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  // Reference model: counts cycles since reset release and pushes the
  // outputs expected to appear after each rising edge.
  initial begin : model
    int          m_cnt;
    int          pos;
    int          slot;
    logic [31:0] m_val;
    logic [7:0]  m_dp;
    logic [7:0]  m_en;
    logic        sup;
    exp_t        e;
`ifdef SEG7_LZ_BLANK_EN
    int          msd;
`endif
    m_cnt = 0;
    m_val = 32'h0;
    m_dp  = 8'h0;
    m_en  = 8'h0;
    forever begin
      @(posedge clk);
      e.seg = 8'hFF;
      e.an  = 8'hFF;
      e.fs  = 1'b0;
      if (rst) begin
        m_cnt = 0;
        m_val = 32'h0;
        m_dp  = 8'h0;
        m_en  = 8'h0;
      end else begin
        pos  = m_cnt % 16;
        slot = (m_cnt / 16) % 8;
        if (pos == 0 && slot == 0) begin
          m_val = value;
          m_dp  = dp_mask;
          m_en  = digit_en;
          e.fs  = 1'b1;
        end
        sup = 1'b0;
`ifdef SEG7_LZ_BLANK_EN
        msd = 0;
        for (int i = 1; i < 8; i++) if (m_val[4*i +: 4] != 4'h0) msd = i;
        if (slot > 0 && slot > msd && !m_dp[slot]) sup = 1'b1;
`endif
        if (pos >= 2 && m_en[slot] && !sup) begin
          e.an       = 8'hFF;
          e.an[slot] = 1'b0;
          e.seg      = {exp_hex(m_val[4*slot +: 4]), ~m_dp[slot]};
        end
        m_cnt++;
      end
      sb_q.push_back(e);
    end
  end

  initial begin : scoreboard
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      checks++;
      if ($countones(~an) > 1) begin
        errors++;
        $display("FAIL sb_onehot t=%0t an=%b (at most one low bit required)", $time, an);
      end
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty t=%0t no expected entry", $time);
      end else begin
        e = sb_q.pop_front();
        checks += 3;
        if (seg !== e.seg) begin
          errors++;
          $display("FAIL sb_seg t=%0t got=%b exp=%b", $time, seg, e.seg);
        end
        if (an !== e.an) begin
          errors++;
          $display("FAIL sb_an t=%0t got=%b exp=%b", $time, an, e.an);
        end
        if (frame_start !== e.fs) begin
          errors++;
          $display("FAIL sb_fs t=%0t got=%b exp=%b", $time, frame_start, e.fs);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    k_cyc++;
  endtask

  task automatic run_to(input int k);
    while (k_cyc < k) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      value    = $urandom;
      dp_mask  = 8'($urandom);
      digit_en = 8'($urandom);
      step();
      checks++;
      if (seg !== 8'hFF || an !== 8'hFF || frame_start !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d seg=%h an=%h fs=%b exp FF/FF/0", i, seg, an, frame_start);
      end
    end
    value    = 32'h7654_3210;
    dp_mask  = 8'h00;
    digit_en = 8'hFF;
    rst      = 1'b0;
    k_cyc    = -1;
    step();
    checks++;
    if (frame_start !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_fs got=%b exp=1", frame_start);
    end
    step();
    checks++;
    if (frame_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_fs_pulse got=%b exp=0", frame_start);
    end
  endtask

  task automatic test_scan();
    run_to(15);
    for (int k = 16; k < 32; k++) begin
      step();
      checks += 2;
      if (an !== ((k < 18) ? 8'hFF : 8'b1111_1101)) begin
        errors++;
        $display("FAIL scan_an k=%0d got=%b", k, an);
      end
      if (seg !== ((k < 18) ? 8'hFF : 8'b1001_1111)) begin
        errors++;
        $display("FAIL scan_seg k=%0d got=%b", k, seg);
      end
    end
  endtask

  task automatic test_tearing();
    run_to(47);
    value = 32'hFFFF_FFFF;
    for (int s = 3; s < 8; s++) begin
      run_to(16 * s + 2);
      checks++;
      if (seg !== {exp_hex(4'(s)), 1'b1}) begin
        errors++;
        $display("FAIL tear_old slot=%0d got=%b exp=%b", s, seg, {exp_hex(4'(s)), 1'b1});
      end
    end
    run_to(130);
    checks++;
    if (seg !== 8'b0111_0001 || an !== 8'b1111_1110) begin
      errors++;
      $display("FAIL tear_new seg=%b an=%b exp seg=01110001 an=11111110", seg, an);
    end
  endtask

  task automatic test_dp_en();
    value    = 32'h0;
    dp_mask  = 8'h01;
    digit_en = 8'h0F;
    run_to(255);
    for (int k = 256; k < 384; k++) begin
      step();
      if (k == 261) begin
        checks++;
        if (seg !== 8'b0000_0010 || an !== 8'b1111_1110) begin
          errors++;
          $display("FAIL dp_digit0 seg=%b an=%b exp seg=00000010 an=11111110", seg, an);
        end
      end
      if (k >= 256 + 64) begin
        checks++;
        if (an !== 8'hFF) begin
          errors++;
          $display("FAIL en_dark k=%0d an=%b exp=11111111", k, an);
        end
      end
    end
  endtask

  task automatic test_lz();
    value    = 32'h0000_00A5;
    dp_mask  = 8'h00;
    digit_en = 8'hFF;
`ifdef SEG7_LZ_BLANK_EN
    for (int k = 384; k < 512; k++) begin
      step();
      if (k == 384 + 18) begin
        checks++;
        if (seg !== 8'b0001_0001) begin
          errors++;
          $display("FAIL lz_digit1 seg=%b exp=00010001", seg);
        end
      end
      if (k >= 384 + 32) begin
        checks++;
        if (an !== 8'hFF) begin
          errors++;
          $display("FAIL lz_dark k=%0d an=%b exp=11111111", k, an);
        end
      end
    end
`else
    run_to(384 + 34);
    checks++;
    if (seg !== 8'b0000_0011 || an !== 8'b1111_1011) begin
      errors++;
      $display("FAIL nolz_digit2 seg=%b an=%b exp seg=00000011 an=11111011", seg, an);
    end
    run_to(511);
`endif
  endtask

  task automatic test_midreset();
    run_to(511);
    value = 32'h7654_3210;
    run_to(597);
    checks++;
    if (an !== 8'b1101_1111) begin
      errors++;
      $display("FAIL mid_pre an=%b exp=11011111", an);
    end
    rst = 1'b1;
    step();
    checks++;
    if (seg !== 8'hFF || an !== 8'hFF || frame_start !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst seg=%h an=%h fs=%b exp FF/FF/0", seg, an, frame_start);
    end
    step();
    value    = 32'h1234_5678;
    dp_mask  = 8'h00;
    digit_en = 8'hFF;
    rst      = 1'b0;
    k_cyc    = -1;
    step();
    checks++;
    if (frame_start !== 1'b1) begin
      errors++;
      $display("FAIL mid_fs got=%b exp=1", frame_start);
    end
    run_to(2);
    checks++;
    if (an !== 8'b1111_1110 || seg !== 8'b0000_0001) begin
      errors++;
      $display("FAIL mid_restart an=%b seg=%b exp an=11111110 seg=00000001", an, seg);
    end
    run_to(140);
  endtask

  initial begin
    rst      = 1'b1;
    value    = 32'h0;
    dp_mask  = 8'h0;
    digit_en = 8'h0;
    test_reset();
    test_scan();
    test_tearing();
    test_dp_en();
    test_lz();
    test_midreset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
